mem_port_ctrl: RTL and testbench



---
 rtl/mem_port_pkg.sv | 16 +
 rtl/mem_port_ctrl.sv | 99 +++++++++
 tb/tb_mem_port_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and default widths for the memory port sequencer.
// The state encoding is shared so a bench or wrapper can decode it consistently.
package mem_port_pkg;

    localparam int MEM_ADDR_WIDTH = 9;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_LEN_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DATA  = 2'd2,
        WR       = 2'd3
    } port_state_t;

endpackage

// File: rtl/mem_port_ctrl.sv
// Initiator-side sequencer for the 512 x 32 synchronous RAM: walks single or burst
// load/store requests over sequential addresses and streams load words back.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int LEN_WIDTH  = MEM_LEN_WIDTH
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_data_output
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    port_state_t           state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  beats_left;

    // Address increment relies on natural wrap of the ADDR_WIDTH counter (511 -> 0).
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr   <= req_addr;
                        beats_left <= req_len;
                        state      <= req_write ? WR : RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rd_ready) begin
                        if (beats_left == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            cur_addr   <= cur_addr + ADDR_ONE;
                            beats_left <= beats_left - LEN_ONE;
                            state      <= RD_ISSUE;
                        end
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        if (beats_left == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            cur_addr   <= cur_addr + ADDR_ONE;
                            beats_left <= beats_left - LEN_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything below decodes the registered state, so strobes fall as soon as
    // clear_n asserts. The RAM holds its output, so read data is passed straight through.
    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign wr_ready    = (state == WR);
    assign rd_valid    = (state == RD_DATA);
    assign ram_read    = (state == RD_ISSUE);
    assign ram_write   = (state == WR) && wr_valid;
    assign ram_address = cur_addr;
    assign ram_data    = (state == WR) ? wr_data : '0;
    assign rd_data     = ram_data_output;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl with a behavioural 512 x 32 synchronous RAM as responder;
// expected writes/reads are queued at request time and consumed by a monitor.
module tb_mem_port_ctrl;
    import mem_port_pkg::*;

    localparam int AW = MEM_ADDR_WIDTH;
    localparam int DW = MEM_DATA_WIDTH;
    localparam int LW = MEM_LEN_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          ram_read;
    logic          ram_write;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_data_output = 32'h5A5A_A5A5;

    always #5 clock = ~clock;

    mem_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock(clock), .clear_n(clear_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
        .ram_data(ram_data), .ram_data_output(ram_data_output)
    );

    // Synchronous RAM: write-on-edge, registered read output held between reads.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clock) begin
        if (ram_write) ram_mem[ram_address] <= ram_data;
        if (ram_read)  ram_data_output <= ram_mem[ram_address];
    end

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } wr_exp_t;

    wr_exp_t       wq[$];
    logic [DW-1:0] rq[$];
    wr_exp_t       wr_front;
    logic [DW-1:0] rd_front;
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] data_buf [16];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int rd_issue_cnt = 0;
    bit pending_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (clear_n) begin
            if (ram_read || ram_write)
                chk("rw_excl", 64'(ram_read & ram_write), 64'd0);
            if (ram_write) begin
                chk("wr_expected", 64'(wq.size() > 0), 64'd1);
                if (wq.size() > 0) begin
                    wr_front = wq.pop_front();
                    chk("wr_addr", 64'(ram_address), 64'(wr_front.waddr));
                    chk("wr_data", 64'(ram_data), 64'(wr_front.wdata));
                    shadow[wr_front.waddr] = wr_front.wdata;
                    $display("WR addr=%0d data=%h", ram_address, ram_data);
                end
            end
            if (rd_valid && rd_ready) begin
                chk("rd_expected", 64'(rq.size() > 0), 64'd1);
                if (rq.size() > 0) begin
                    rd_front = rq.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(rd_front));
                    $display("RD data=%h", rd_data);
                end
            end else if (rd_valid && rq.size() > 0) begin
                chk("rd_hold", 64'(rd_data), 64'(rq[0]));
            end
            if (ram_read) rd_issue_cnt++;
            if (done)     done_cnt++;
        end
    end

    task automatic start_req(input bit w, input int a, input int n);
        @(posedge clock); #1;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = AW'(a);
        req_len   = LW'(n - 1);
        @(negedge clock);
        chk("done", 64'(done), 64'(pending_done));
        pending_done = 1'b0;
        chk("req_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic do_store(input int a, input int n, input int gap_pct);
        int i = 0;
        int cyc = 0;
        start_req(1'b1, a, n);
        for (int k = 0; k < n; k++)
            wq.push_back(wr_exp_t'{waddr: AW'((a + k) % DEPTH), wdata: data_buf[k]});
        exp_done++;
        while (i < n && cyc < 200) begin
            @(posedge clock); #1;
            req_valid = 1'b0;
            wr_valid  = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
            wr_data   = data_buf[i];
            @(negedge clock);
            cyc++;
            if (cyc == 1) chk("wr_busy", 64'(busy), 64'd1);
            if (wr_valid && wr_ready) i++;
        end
        chk("wr_beats", 64'(i), 64'(n));
        if (gap_pct == 0) chk("wr_cycles", 64'(cyc), 64'(n));
        pending_done = 1'b1;
    endtask

    task automatic do_load(input int a, input int n, input int stall_beat, input int stall_cyc);
        int beat = 0;
        int sc = 0;
        int guard = 0;
        int issue0;
        start_req(1'b0, a, n);
        issue0 = rd_issue_cnt;
        for (int k = 0; k < n; k++) rq.push_back(shadow[(a + k) % DEPTH]);
        exp_done++;
        while (beat < n && guard < 200) begin
            @(posedge clock); #1;
            req_valid = 1'b0;
            rd_ready  = !(beat == stall_beat && sc < stall_cyc);
            @(negedge clock);
            guard++;
            if (guard == 1) chk("rd_busy", 64'(busy), 64'd1);
            if (rd_valid) begin
                if (rd_ready) beat++;
                else sc++;
            end
        end
        chk("rd_beats", 64'(beat), 64'(n));
        chk("rd_issues", 64'(rd_issue_cnt - issue0), 64'(n));
        pending_done = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            wr_valid  = 1'b0;
            rd_ready  = 1'b0;
            req_valid = 1'b0;
            @(negedge clock);
            if (k == 0) begin
                chk("done", 64'(done), 64'(pending_done));
                pending_done = 1'b0;
            end else if (k == 1) begin
                chk("done_pulse", 64'(done), 64'd0);
            end
        end
    endtask

    initial begin
        // Reset values, with a store word offered to prove it cannot leak through.
        wr_valid = 1'b1;
        wr_data  = 32'hFFFF_FFFF;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_ram_read", 64'(ram_read), 64'd0);
        chk("rst_ram_write", 64'(ram_write), 64'd0);
        chk("rst_ram_address", 64'(ram_address), 64'd0);
        chk("rst_ram_data", 64'(ram_data), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'h5A5A_A5A5);
        @(posedge clock); #1;
        wr_valid = 1'b0;
        clear_n  = 1'b1;

        // Single store then load.
        data_buf[0] = 32'hDEAD_BEEF;
        do_store(5, 1, 0);
        do_load(5, 1, -1, 0);

        // Store burst, then load burst with a stall on beat 2.
        for (int k = 0; k < 4; k++) data_buf[k] = DW'(k + 1);
        do_store(10, 4, 0);
        do_load(10, 4, 1, 3);

        // Wrap-around 510, 511, 0.
        data_buf[0] = 32'h0000_000A;
        data_buf[1] = 32'h0000_000B;
        data_buf[2] = 32'h0000_000C;
        do_store(510, 3, 0);
        do_load(0, 1, -1, 0);
        do_load(510, 3, -1, 0);

        // Reset during beat 2 of a 4-beat store over prefilled words.
        for (int k = 0; k < 4; k++) data_buf[k] = 32'h1111_0000 + DW'(k);
        do_store(100, 4, 0);
        for (int k = 0; k < 4; k++) data_buf[k] = 32'hAAAA_0000 + DW'(k);
        start_req(1'b1, 100, 4);
        for (int k = 0; k < 4; k++)
            wq.push_back(wr_exp_t'{waddr: AW'(100 + k), wdata: data_buf[k]});
        @(posedge clock); #1;
        req_valid = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = data_buf[0];
        @(negedge clock);
        chk("abort_b1_ready", 64'(wr_ready), 64'd1);
        @(posedge clock); #1;
        wr_data = data_buf[1];
        #2 clear_n = 1'b0;
        #1;
        chk("abort_ram_write", 64'(ram_write), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_wr_ready", 64'(wr_ready), 64'd0);
        chk("abort_ram_data", 64'(ram_data), 64'd0);
        chk("abort_ram_address", 64'(ram_address), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clock);
        chk("abort_q", 64'(wq.size()), 64'd3);
        wq.delete();
        @(posedge clock); #1;
        wr_valid = 1'b0;
        clear_n  = 1'b1;
        do_load(100, 4, -1, 0);

        // Back-to-back: a load requested in the done cycle of a store, and vice versa.
        data_buf[0] = 32'hCAFE_0001;
        data_buf[1] = 32'hCAFE_0002;
        do_store(200, 2, 0);
        do_load(200, 2, 0, 1);
        data_buf[0] = 32'hBEEF_0100;
        do_store(201, 1, 0);
        do_load(200, 2, -1, 0);

        // Store with random wr_valid gaps, load with random stalls.
        for (int k = 0; k < 16; k++) data_buf[k] = $urandom;
        do_store(505, 16, 40);
        do_load(505, 16, int'($urandom_range(15)), int'($urandom_range(1, 4)));

        idle(3);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
